linebuf_ctrl: RTL and testbench

Sequencer for the multi-line pixel buffer in the HDMI filter pipeline. Tracks frame and line position from the incoming `dv/hs/vs` stream and drives the buffer memories' address, enable and write-enable. Runs a fill/run state machine that marks when a full `BUF_DEPTH`-line window is present, and flags horizontal border columns and malformed lines. Sits between the video timing source and the line buffer, in the same clock domain.

---
 rtl/linebuf_pkg.sv | 24 ++
 rtl/linebuf_ctrl_edge_det.sv | 40 ++++
 rtl/linebuf_ctrl.sv | 156 +++++++++++++++
 tb/tb_linebuf_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/linebuf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : linebuf_pkg
//  Purpose  : Shared state encoding and helpers for the line-buffer sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package linebuf_pkg;

    // Sequencer states; the numeric values are visible on state_o.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Half-height of the window: how many columns from a border the window
    // centre must be before the full kernel fits horizontally.
    function automatic int border_radius(input int depth);
        return depth / 2;
    endfunction

endpackage : linebuf_pkg
`default_nettype wire

// File: rtl/linebuf_ctrl_edge_det.sv
`default_nettype none
// ============================================================================
//  Module   : edge_det
//  Purpose  : Registered edge detector. Delays the input by one cycle and
//             flags either the rising or the falling edge against that copy.
//  Revision : 1.0  initial release
// ============================================================================
module edge_det #(
    parameter bit RISING = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic dly_o,
    output logic edge_o
);

    logic sig_q;

    // One-cycle delayed copy of the input, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign dly_o = sig_q;

    generate
        if (RISING) begin : g_rise
            assign edge_o = sig_i & ~sig_q;
        end else begin : g_fall
            assign edge_o = ~sig_i & sig_q;
        end
    endgenerate

endmodule : edge_det
`default_nettype wire

// File: rtl/linebuf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : linebuf_ctrl
//  Purpose  : Line-buffer sequencer. Tracks column/row position of the video
//             stream, drives buffer address/enables, and runs the fill/run
//             state machine that marks when a full window is available.
//  Revision : 1.0  initial release
// ============================================================================
module linebuf_ctrl
    import linebuf_pkg::*;
#(
    parameter int SCREENWIDTH  = 1600,
    parameter int SCREENHEIGHT = 900,
    parameter int BUF_DEPTH    = 5,
    parameter int AW           = 11,
    parameter int RW           = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dv_i,
    input  logic          hs_i,
    input  logic          vs_i,
    output logic [AW-1:0] rd_addr_o,
    output logic [AW-1:0] wr_addr_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic [1:0]    state_o,
    output logic          win_valid_o,
    output logic          edge_l_o,
    output logic          edge_r_o,
    output logic          len_err_o,
    output logic          row_err_o,
    output logic          dv_o,
    output logic          hs_o,
    output logic          vs_o
);

    localparam int            c_r         = border_radius(BUF_DEPTH);
    localparam logic [AW-1:0] c_width     = AW'(SCREENWIDTH);
    localparam logic [AW-1:0] c_radius    = AW'(c_r);
    localparam logic [AW-1:0] c_right     = AW'(SCREENWIDTH - 1 - c_r);
    localparam logic [RW-1:0] c_height    = RW'(SCREENHEIGHT);
    localparam logic [RW-1:0] c_fill_rows = RW'(BUF_DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [RW-1:0] row_q, row_d;
    logic          len_err_q, len_err_d;
    logic          row_err_q, row_err_d;
    logic          abandon_q, abandon_d;
    logic          hs_q;

    logic          dv_dly;
    logic          vs_dly;
    logic          line_end;
    logic          frame_start;
    logic [RW-1:0] row_inc;
    logic [AW-1:0] col;
    logic          win_valid;

    edge_det #(.RISING(1'b0)) u_dv_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (dv_i),
        .dly_o  (dv_dly),
        .edge_o (line_end)
    );

    edge_det #(.RISING(1'b1)) u_vs_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (vs_i),
        .dly_o  (vs_dly),
        .edge_o (frame_start)
    );

    // Column counter restarts on every blanking cycle.
    assign addr_d  = dv_i ? (addr_q + AW'(1)) : '0;
    // Row count saturates at the frame height.
    assign row_inc = (row_q == c_height) ? row_q : (row_q + RW'(1));

    // State, row and error registers plus the delayed hsync.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            row_q     <= '0;
            len_err_q <= 1'b0;
            row_err_q <= 1'b0;
            abandon_q <= 1'b0;
            hs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            row_q     <= row_d;
            len_err_q <= len_err_d;
            row_err_q <= row_err_d;
            abandon_q <= abandon_d;
            hs_q      <= hs_i;
        end
    end

    // Next-state logic: frame start overrides everything; a line end only
    // counts when a frame is active and the line was not cut by a frame start.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        len_err_d = 1'b0;
        row_err_d = 1'b0;
        abandon_d = abandon_q;

        if (line_end) begin
            abandon_d = 1'b0;
        end

        if (frame_start) begin
            state_d = ST_FILL;
            row_d   = '0;
            if (dv_i) begin
                abandon_d = 1'b1;
            end
        end else if (line_end && !abandon_q && (state_q != ST_IDLE)) begin
            row_d     = row_inc;
            len_err_d = (addr_q != c_width);
            case (state_q)
                ST_FILL: if (row_inc == c_fill_rows) state_d = ST_RUN;
                ST_RUN:  if (row_inc == c_height)    state_d = ST_DONE;
                ST_DONE: row_err_d = 1'b1;
                default: ;
            endcase
        end
    end

    assign col       = dv_dly ? (addr_q - AW'(1)) : '0;
    assign win_valid = dv_dly & (state_q == ST_RUN);

    assign rd_addr_o   = addr_q;
    assign wr_addr_o   = addr_q - AW'(1);
    assign mem_en_o    = dv_i | dv_dly;
    assign mem_we_o    = dv_dly & ((state_q == ST_FILL) || (state_q == ST_RUN));
    assign col_o       = col;
    assign row_o       = row_q;
    assign state_o     = state_q;
    assign win_valid_o = win_valid;
    assign edge_l_o    = win_valid & (col < c_radius);
    assign edge_r_o    = win_valid & (col > c_right);
    assign len_err_o   = len_err_q;
    assign row_err_o   = row_err_q;
    assign dv_o        = dv_dly;
    assign hs_o        = hs_q;
    assign vs_o        = vs_dly;

endmodule : linebuf_ctrl
`default_nettype wire

// File: tb/tb_linebuf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_linebuf_ctrl
//  Purpose  : Directed testbench for linebuf_ctrl (8x6 frame, 5-line window).
//  Revision : 1.0  initial release
// ============================================================================
module tb_linebuf_ctrl;

    localparam int SW = 8;
    localparam int SH = 6;
    localparam int BD = 5;
    localparam int AW = 11;
    localparam int RW = 10;

    localparam int S_IDLE = 0;
    localparam int S_FILL = 1;
    localparam int S_RUN  = 2;
    localparam int S_DONE = 3;

    logic          clk = 1'b0;
    logic          rst, dv_i, hs_i, vs_i;
    logic [AW-1:0] rd_addr_o, wr_addr_o, col_o;
    logic [RW-1:0] row_o;
    logic [1:0]    state_o;
    logic          mem_en_o, mem_we_o, win_valid_o, edge_l_o, edge_r_o;
    logic          len_err_o, row_err_o, dv_o, hs_o, vs_o;

    linebuf_ctrl #(
        .SCREENWIDTH (SW),
        .SCREENHEIGHT(SH),
        .BUF_DEPTH   (BD),
        .AW          (AW),
        .RW          (RW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dv_i       (dv_i),
        .hs_i       (hs_i),
        .vs_i       (vs_i),
        .rd_addr_o  (rd_addr_o),
        .wr_addr_o  (wr_addr_o),
        .mem_en_o   (mem_en_o),
        .mem_we_o   (mem_we_o),
        .col_o      (col_o),
        .row_o      (row_o),
        .state_o    (state_o),
        .win_valid_o(win_valid_o),
        .edge_l_o   (edge_l_o),
        .edge_r_o   (edge_r_o),
        .len_err_o  (len_err_o),
        .row_err_o  (row_err_o),
        .dv_o       (dv_o),
        .hs_o       (hs_o),
        .vs_o       (vs_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int a_we, a_win, a_el, a_er, a_len, a_rerr;

    typedef struct {
        bit vs;
        int npix;
        int st;
        int row;
        int we;
        int win;
        int el;
        int er;
        int len;
        int rerr;
    } line_vec_t;

    line_vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_acc();
        a_we = 0; a_win = 0; a_el = 0; a_er = 0; a_len = 0; a_rerr = 0;
    endtask

    // Apply inputs and sample outputs at the following falling edge.
    task automatic drive(input logic dv, input logic hs, input logic vs, input logic rs);
        dv_i = dv; hs_i = hs; vs_i = vs; rst = rs;
        @(negedge clk);
        if (mem_we_o)    a_we++;
        if (win_valid_o) a_win++;
        if (edge_l_o)    a_el++;
        if (edge_r_o)    a_er++;
        if (len_err_o)   a_len++;
        if (row_err_o)   a_rerr++;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic dv, input logic hs, input logic vs, input logic rs);
        drive(dv, hs, vs, rs);
        adv();
    endtask

    task automatic frame();
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // n pixels followed by a two-cycle blanking gap.
    task automatic line(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //           vs npix state   row we win el er len rerr
        tbl[0]  = '{1, 8, S_FILL, 1, 8, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 8, S_FILL, 2, 8, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 8, S_FILL, 3, 8, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 8, S_RUN,  4, 8, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 8, S_RUN,  5, 8, 8, 2, 2, 0, 0};
        tbl[5]  = '{0, 8, S_DONE, 6, 8, 8, 2, 2, 0, 0};
        tbl[6]  = '{0, 8, S_DONE, 6, 0, 0, 0, 0, 0, 1};
        tbl[7]  = '{1, 7, S_FILL, 1, 7, 0, 0, 0, 1, 0};
        tbl[8]  = '{0, 9, S_FILL, 2, 9, 0, 0, 0, 1, 0};
        tbl[9]  = '{0, 8, S_FILL, 3, 8, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 8, S_RUN,  4, 8, 0, 0, 0, 0, 0};

        dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; rst = 1'b1;
        adv();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset state.
        chk("rst rd_addr", rd_addr_o, 0);
        chk("rst wr_addr", wr_addr_o, 2047);
        chk("rst col", col_o, 0);
        chk("rst row", row_o, 0);
        chk("rst state", state_o, S_IDLE);
        chk("rst mem_en", mem_en_o, 0);
        chk("rst mem_we", mem_we_o, 0);
        chk("rst win", win_valid_o, 0);
        chk("rst len_err", len_err_o, 0);
        chk("rst dv_o", dv_o, 0);

        // Line before any frame start is ignored.
        clr_acc();
        line(8);
        chk("idle we", a_we, 0);
        chk("idle state", state_o, S_IDLE);

        // Table-driven line vectors.
        for (int k = 0; k < 11; k++) begin
            if (tbl[k].vs) frame();
            clr_acc();
            line(tbl[k].npix);
            chk($sformatf("v%0d state", k), state_o, tbl[k].st);
            chk($sformatf("v%0d row", k), row_o, tbl[k].row);
            chk($sformatf("v%0d we", k), a_we, tbl[k].we);
            chk($sformatf("v%0d win", k), a_win, tbl[k].win);
            chk($sformatf("v%0d edge_l", k), a_el, tbl[k].el);
            chk($sformatf("v%0d edge_r", k), a_er, tbl[k].er);
            chk($sformatf("v%0d len_err", k), a_len, tbl[k].len);
            chk($sformatf("v%0d row_err", k), a_rerr, tbl[k].rerr);
        end

        // RUN line, cycle by cycle.
        for (int i = 0; i < 10; i++) begin
            int  ea;
            bit  edv;
            int  ec;
            drive(i < 8, i == 8, 1'b0, 1'b0);
            ea  = (i <= 8) ? i : 0;
            edv = (i >= 1) && (i <= 8);
            ec  = edv ? i - 1 : 0;
            chk($sformatf("run%0d rd_addr", i), rd_addr_o, ea);
            chk($sformatf("run%0d wr_addr", i), wr_addr_o, (ea + 2047) % 2048);
            chk($sformatf("run%0d col", i), col_o, ec);
            chk($sformatf("run%0d win", i), win_valid_o, edv);
            chk($sformatf("run%0d edge_l", i), edge_l_o, edv && ec < 2);
            chk($sformatf("run%0d edge_r", i), edge_r_o, edv && ec > 5);
            chk($sformatf("run%0d mem_we", i), mem_we_o, edv);
            chk($sformatf("run%0d mem_en", i), mem_en_o, (i < 8) || edv);
            chk($sformatf("run%0d dv_o", i), dv_o, edv);
            chk($sformatf("run%0d hs_o", i), hs_o, i == 9);
            adv();
        end
        chk("run row", row_o, 5);

        // Short line in RUN: single len_err one cycle after dv_i falls.
        for (int i = 0; i < 9; i++) begin
            drive(i < 7, 1'b0, 1'b0, 1'b0);
            chk($sformatf("short%0d len_err", i), len_err_o, i == 8);
            adv();
        end
        chk("short row", row_o, 6);
        chk("short state", state_o, S_DONE);

        // Frame start at pixel 3 of line 3.
        frame();
        line(8);
        line(8);
        chk("pre-vs row", row_o, 2);
        clr_acc();
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, 1'b0, (i == 2) || (i == 3), 1'b0);
            if (i == 3) begin
                chk("midvs row", row_o, 0);
                chk("midvs state", state_o, S_FILL);
                chk("midvs vs_o", vs_o, 1);
            end
            adv();
        end
        chk("midvs len_err", a_len, 0);
        chk("midvs row after", row_o, 0);
        line(8);
        chk("post-vs row", row_o, 1);

        // Frame start coincides with a (short) line end.
        clr_acc();
        for (int i = 0; i < 9; i++) begin
            drive(i < 7, 1'b0, i == 7, 1'b0);
            if (i == 8) begin
                chk("coinc row", row_o, 0);
                chk("coinc state", state_o, S_FILL);
            end
            adv();
        end
        chk("coinc len_err", a_len, 0);

        // Reset mid-line in RUN.
        frame();
        for (int k = 0; k < 4; k++) line(8);
        chk("pre-rst state", state_o, S_RUN);
        clr_acc();
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, 1'b0, 1'b0, i == 3);
            if (i == 4) begin
                chk("mrst rd_addr", rd_addr_o, 0);
                chk("mrst wr_addr", wr_addr_o, 2047);
                chk("mrst col", col_o, 0);
                chk("mrst row", row_o, 0);
                chk("mrst state", state_o, S_IDLE);
                chk("mrst mem_we", mem_we_o, 0);
                chk("mrst win", win_valid_o, 0);
                chk("mrst dv_o", dv_o, 0);
                chk("mrst len_err", len_err_o, 0);
            end
            adv();
        end
        line(8);
        chk("mrst we", a_we, 3);
        chk("mrst idle", state_o, S_IDLE);
        clr_acc();
        line(8);
        chk("after-rst we", a_we, 0);
        frame();
        clr_acc();
        line(8);
        chk("refill we", a_we, 8);
        chk("refill state", state_o, S_FILL);
        chk("refill row", row_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_linebuf_ctrl
`default_nettype wire
